// File: rtl/register_command_controller.sv
// Byte-frame command decoder sitting between the UART and the register file.
// Write frame: WRITE_OPCODE, addr, data.  Read frame: READ_OPCODE, addr -> read data is sent back over the transmitter.
module register_command_controller #(
    parameter int                    DATA_WIDTH          = 8,
    parameter int                    REGISTER_FILE_DEPTH = 16,
    parameter int                    READ_TIMEOUT        = 8,
    parameter logic [DATA_WIDTH-1:0] WRITE_OPCODE        = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] READ_OPCODE         = 8'hBB,
    localparam int                   AW                  = $clog2(REGISTER_FILE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_data_valid,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_data_valid,
    input  logic                  tx_busy,
    output logic [AW-1:0]         address,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    output logic                  busy,
    output logic                  command_error,
    output logic                  read_timeout_error
);

    localparam int                    CW      = $clog2(READ_TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(REGISTER_FILE_DEPTH);
    localparam logic [CW-1:0]         CNT_MAX = CW'(READ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_EXEC,
        RD_ADDR,
        RD_EXEC,
        TX_WAIT
    } state_t;

    state_t                state, state_d;
    logic [AW-1:0]         address_d;
    logic [DATA_WIDTH-1:0] write_data_d, tx_data_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic                  cmd_err_d, to_err_d, tx_valid_d;
    logic                  addr_ok;

    assign addr_ok = (rx_data < DEPTH_W);

    always_comb begin
        state_d      = state;
        address_d    = address;
        write_data_d = write_data;
        tx_data_d    = tx_data;
        cnt_d        = cnt;
        cmd_err_d    = 1'b0;
        to_err_d     = 1'b0;
        tx_valid_d   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_data_valid) begin
                    if (rx_data == WRITE_OPCODE)     state_d = WR_ADDR;
                    else if (rx_data == READ_OPCODE) state_d = RD_ADDR;
                    else                             cmd_err_d = 1'b1;
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (rx_data_valid) begin
                    if (!addr_ok) begin
                        cmd_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        address_d = rx_data[AW-1:0];
                        cnt_d     = '0;
                        state_d   = (state == WR_ADDR) ? WR_DATA : RD_EXEC;
                    end
                end
            end
            WR_DATA: begin
                if (rx_data_valid) begin
                    write_data_d = rx_data;
                    state_d      = WR_EXEC;
                end
            end
            WR_EXEC: state_d = IDLE;
            RD_EXEC: begin
                // valid wins over timeout when both land on the last allowed cycle
                if (read_data_valid) begin
                    tx_data_d = read_data;
                    cnt_d     = '0;
                    state_d   = TX_WAIT;
                end else if (cnt == CNT_MAX) begin
                    to_err_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    tx_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            address            <= '0;
            write_data         <= '0;
            tx_data            <= '0;
            cnt                <= '0;
            command_error      <= 1'b0;
            read_timeout_error <= 1'b0;
            tx_data_valid      <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state              <= state_d;
            address            <= address_d;
            write_data         <= write_data_d;
            tx_data            <= tx_data_d;
            cnt                <= cnt_d;
            command_error      <= cmd_err_d;
            read_timeout_error <= to_err_d;
            tx_data_valid      <= tx_valid_d;
            busy               <= (state_d != IDLE);
        end
    end

    // strobes decode straight from the state register, so they are glitch-free and clear with reset
    assign write_enable = (state == WR_EXEC);
    assign read_enable  = (state == RD_EXEC);

endmodule

// File: tb/tb_register_command_controller.sv
// Scoreboard bench: stimulus pushes expected events, a monitor pops them as the DUT strobes.
// A behavioural register file with programmable read latency sits on the register-file side.
module tb_register_command_controller;

    typedef enum int {EV_WR, EV_TX, EV_ERR, EV_TO} ev_kind_t;
    typedef struct {
        ev_kind_t    k;
        logic [3:0]  a;
        logic [7:0]  d;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic [7:0] read_data;
    logic       read_data_valid;
    logic       tx_busy;
    logic [3:0] address;
    logic       write_enable, read_enable;
    logic [7:0] write_data, tx_data;
    logic       tx_data_valid, busy, command_error, read_timeout_error;

    ev_t        exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] model_mem [16];
    logic [7:0] rf [16];
    int         lat = 0;
    int         busy_mode = 2;  // 0 random, 1 held busy, 2 idle

    always #5 clk = ~clk;

    register_command_controller dut (
        .clk                (clk),
        .reset              (reset),
        .rx_data            (rx_data),
        .rx_data_valid      (rx_data_valid),
        .read_data          (read_data),
        .read_data_valid    (read_data_valid),
        .tx_busy            (tx_busy),
        .address            (address),
        .write_enable       (write_enable),
        .read_enable        (read_enable),
        .write_data         (write_data),
        .tx_data            (tx_data),
        .tx_data_valid      (tx_data_valid),
        .busy               (busy),
        .command_error      (command_error),
        .read_timeout_error (read_timeout_error)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(ev_kind_t k, logic [3:0] a, logic [7:0] d);
        ev_t e;
        e.k = k; e.a = a; e.d = d;
        exp_q.push_back(e);
    endfunction

    task automatic pop_cmp(ev_kind_t k, logic [3:0] a, logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected no event", k);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.k);
            if (k == e.k && k == EV_WR) begin
                check("wr_address", a, e.a);
                check("wr_data", d, e.d);
            end
            if (k == e.k && k == EV_TX) check("tx_data", d, e.d);
        end
    endtask

    // register file: writes land on write_enable, reads answer after `lat` cycles of read_enable
    initial begin
        int rcnt;
        rcnt = 0;
        read_data_valid = 1'b0;
        read_data = '0;
        forever begin
            @(negedge clk);
            if (write_enable) rf[address] = write_data;
            if (read_enable) begin
                if (rcnt == lat) begin
                    read_data_valid = 1'b1;
                    read_data = rf[address];
                end else begin
                    read_data_valid = 1'b0;
                end
                rcnt++;
            end else begin
                read_data_valid = 1'b0;
                rcnt = 0;
            end
        end
    end

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (busy_mode)
                0:       tx_busy = ($urandom_range(0, 2) == 0);
                1:       tx_busy = 1'b1;
                default: tx_busy = 1'b0;
            endcase
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (write_enable || read_enable)
                    check("strobe_overlap", {write_enable & read_enable,
                          (command_error | read_timeout_error)}, 0);
                if (write_enable)       pop_cmp(EV_WR, address, write_data);
                if (tx_data_valid)      pop_cmp(EV_TX, 4'h0, tx_data);
                if (command_error)      pop_cmp(EV_ERR, 4'h0, 8'h00);
                if (read_timeout_error) pop_cmp(EV_TO, 4'h0, 8'h00);
            end
        end
    end

    task automatic send_byte(logic [7:0] b, int gap);
        rx_data = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d, expected idle", busy, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic write_frame(logic [7:0] a, logic [7:0] d, int gap);
        send_byte(8'hAA, gap);
        if (a >= 8'd16) begin
            push(EV_ERR, 4'h0, 8'h00);
            send_byte(a, 0);
        end else begin
            send_byte(a, gap);
            push(EV_WR, a[3:0], d);
            model_mem[a[3:0]] = d;
            send_byte(d, 0);
        end
    endtask

    task automatic read_frame(logic [7:0] a, int l, int gap);
        lat = l;
        send_byte(8'hBB, gap);
        if (a >= 8'd16)  push(EV_ERR, 4'h0, 8'h00);
        else if (l >= 8) push(EV_TO, 4'h0, 8'h00);
        else             push(EV_TX, 4'h0, model_mem[a[3:0]]);
        send_byte(a, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic       seen, changed;
        logic [7:0] held, b, a, d;
        int         r, g;

        for (int i = 0; i < 16; i++) begin
            model_mem[i] = '0;
            rf[i] = '0;
        end
        reset = 1'b1;
        rx_data = '0;
        rx_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {address, write_data, tx_data, write_enable, read_enable,
              tx_data_valid, busy, command_error, read_timeout_error}, 0);
        reset = 1'b0;
        @(negedge clk);

        // write frame AA,0E,F4
        write_frame(8'h0E, 8'hF4, 1);
        check("wr_latency", {write_enable, address, write_data, command_error}, {1'b1, 4'hE, 8'hF4, 1'b0});
        wait_idle();

        // read-back AA,05,3C then BB,05
        write_frame(8'h05, 8'h3C, 1);
        wait_idle();
        read_frame(8'h05, 2, 1);
        check("rd_enable_rise", read_enable, 1);
        wait_idle();
        check("rd_tx_data", tx_data, 8'h3C);

        // unknown opcode
        push(EV_ERR, 4'h0, 8'h00);
        send_byte(8'h12, 0);
        check("bad_op_err", {command_error, write_enable, read_enable}, 3'b100);
        @(negedge clk);
        check("bad_op_pulse", command_error, 0);
        wait_idle();

        // out-of-range address
        read_frame(8'h20, 0, 1);
        check("bad_addr_err", {command_error, read_enable}, 2'b10);
        @(negedge clk);
        check("bad_addr_pulse", {command_error, read_enable}, 0);
        wait_idle();

        // transmit stall
        busy_mode = 1;
        read_frame(8'h05, 1, 1);
        seen = 1'b0; changed = 1'b0; held = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_data_valid) seen = 1'b1;
            if (i == 5) held = tx_data;
            if (i > 5 && tx_data !== held) changed = 1'b1;
        end
        check("stall_no_valid", seen, 0);
        check("stall_stable", {changed, held}, {1'b0, 8'h3C});
        busy_mode = 2;
        @(negedge clk);
        check("stall_still_low", tx_data_valid, 0);
        @(negedge clk);
        check("stall_release", {tx_data_valid, tx_data}, {1'b1, 8'h3C});
        wait_idle();

        // timeout with no response
        read_frame(8'h03, 255, 0);
        n = 0;
        while (read_enable && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("timeout_re_cycles", n, 8);
        check("timeout_err_idle", {read_timeout_error, busy}, 2'b10);
        wait_idle();

        // latency boundary: last allowed cycle vs one too late
        read_frame(8'h05, 7, 0);
        wait_idle();
        read_frame(8'h05, 8, 0);
        wait_idle();

        // asynchronous reset mid-frame
        send_byte(8'hAA, 1);
        send_byte(8'h03, 1);
        #2 reset = 1'b1;
        #1 check("async_reset", {address, write_data, tx_data, write_enable, read_enable,
                 tx_data_valid, busy, command_error, read_timeout_error}, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        push(EV_ERR, 4'h0, 8'h00);
        send_byte(8'h77, 0);
        check("post_reset_err", {command_error, write_enable}, 2'b10);
        wait_idle();

        // randomized traffic
        busy_mode = 0;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            g = $urandom_range(0, 2);
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            if (r < 4) begin
                write_frame(a, d, g);
            end else if (r < 8) begin
                read_frame(a, $urandom_range(0, 9), g);
            end else if (r == 8) begin
                b = 8'($urandom);
                if (b == 8'hAA || b == 8'hBB) b = 8'h00;
                push(EV_ERR, 4'h0, 8'h00);
                send_byte(b, 0);
            end else begin
                a = 8'($urandom_range(16, 255));
                if ($urandom_range(0, 1) == 0) write_frame(a, d, g);
                else                           read_frame(a, 0, g);
            end
            wait_idle();
        end

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
